// File: rtl/bp_cfg_loader.sv
// -----------------------------------------------------------------------------
// bp_cfg_loader
//
// Boot-time configuration sequencer for a multicore build. A start pulse
// captures the domain id and the cache/CCE modes, then the block walks the
// per-tile config bus in three phases:
//   FREEZE   : addr 0x0000 <= 1 for cores 0..N-1
//   CONFIG   : for each core, addr 0x0004..0x0014 <= core id, did, I$ mode,
//              D$ mode, CCE mode
//   UNFREEZE : addr 0x0000 <= 0 for cores 0..N-1
// That makes exactly 7*N writes per run. Writes use a valid/ready handshake:
// a write retires on a cycle with cfg_v_o & cfg_ready_i, and all cfg_*
// outputs hold while the bus stalls.
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   reset_i        synchronous active-high reset (aborts a run)
//   start_i        begin a run; honoured only in IDLE or DONE
//   did_i          domain id, captured at start
//   icache_mode_i  I$ mode, captured at start
//   dcache_mode_i  D$ mode, captured at start
//   cce_mode_i     CCE mode, captured at start
//   cfg_v_o        config write valid
//   cfg_core_o     target core of the write
//   cfg_addr_o     config register address
//   cfg_data_o     write data, zero-extended
//   cfg_ready_i    bus accepts the write this cycle
//   busy_o         run in progress
//   done_o         last run completed
// -----------------------------------------------------------------------------
module bp_cfg_loader #(
    parameter int num_core_p         = 1,
    parameter int cfg_addr_width_p   = 16,
    parameter int cfg_data_width_p   = 32,
    parameter int io_noc_did_width_p = 3,
    localparam int lg_num_core       = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    input  logic [io_noc_did_width_p-1:0] did_i,
    input  logic [1:0]                    icache_mode_i,
    input  logic [1:0]                    dcache_mode_i,
    input  logic                          cce_mode_i,
    output logic                          cfg_v_o,
    output logic [lg_num_core-1:0]        cfg_core_o,
    output logic [cfg_addr_width_p-1:0]   cfg_addr_o,
    output logic [cfg_data_width_p-1:0]   cfg_data_o,
    input  logic                          cfg_ready_i,
    output logic                          busy_o,
    output logic                          done_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FREEZE   = 3'd1,
        S_CONFIG   = 3'd2,
        S_UNFREEZE = 3'd3,
        S_DONE     = 3'd4
    } state_e;

    localparam logic [lg_num_core-1:0] last_core  = lg_num_core'(num_core_p - 1);
    localparam logic [2:0]             last_field = 3'd4;

    localparam logic [cfg_addr_width_p-1:0] freeze_addr = cfg_addr_width_p'(16'h0000);
    localparam logic [cfg_data_width_p-1:0] data_one    = cfg_data_width_p'(1'b1);
    localparam logic [cfg_data_width_p-1:0] data_zero   = cfg_data_width_p'(1'b0);

    state_e                          state_r;
    logic [lg_num_core-1:0]          core_cnt_r;
    logic [2:0]                      field_cnt_r;
    logic [io_noc_did_width_p-1:0]   did_r;
    logic [1:0]                      icache_mode_r;
    logic [1:0]                      dcache_mode_r;
    logic                            cce_mode_r;

    logic                            retire_s;
    logic [lg_num_core-1:0]          core_next_s;
    logic [2:0]                      field_next_s;

    // Register address of CONFIG field f: 0x0004 + 4*f.
    function automatic logic [cfg_addr_width_p-1:0] field_addr(input logic [2:0] field);
        return cfg_addr_width_p'({field + 3'd1, 2'b00});
    endfunction

    // Write data for CONFIG field f of a given core, taken from the values
    // captured at start so a whole run uses one consistent set.
    function automatic logic [cfg_data_width_p-1:0] field_data(
        input logic [2:0]             field,
        input logic [lg_num_core-1:0] core
    );
        logic [cfg_data_width_p-1:0] val;
        case (field)
            3'd0:    val = cfg_data_width_p'(core);
            3'd1:    val = cfg_data_width_p'(did_r);
            3'd2:    val = cfg_data_width_p'(icache_mode_r);
            3'd3:    val = cfg_data_width_p'(dcache_mode_r);
            3'd4:    val = cfg_data_width_p'(cce_mode_r);
            default: val = data_zero;
        endcase
        return val;
    endfunction

    // Only a retiring write moves the sequence forward.
    assign retire_s     = cfg_v_o & cfg_ready_i;
    assign core_next_s  = core_cnt_r + lg_num_core'(1);
    assign field_next_s = field_cnt_r + 3'd1;

    // Sequencer FSM: state, counters, captured fields and all registered outputs.
    // The outputs always present the write selected by the counters, so each
    // retire loads the following write in the same edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r       <= S_IDLE;
            core_cnt_r    <= '0;
            field_cnt_r   <= 3'd0;
            did_r         <= '0;
            icache_mode_r <= 2'd0;
            dcache_mode_r <= 2'd0;
            cce_mode_r    <= 1'b0;
            cfg_v_o       <= 1'b0;
            cfg_core_o    <= '0;
            cfg_addr_o    <= '0;
            cfg_data_o    <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        did_r         <= did_i;
                        icache_mode_r <= icache_mode_i;
                        dcache_mode_r <= dcache_mode_i;
                        cce_mode_r    <= cce_mode_i;
                        core_cnt_r    <= '0;
                        field_cnt_r   <= 3'd0;
                        state_r       <= S_FREEZE;
                        // First freeze write goes out on the very next cycle.
                        cfg_v_o       <= 1'b1;
                        cfg_core_o    <= '0;
                        cfg_addr_o    <= freeze_addr;
                        cfg_data_o    <= data_one;
                        busy_o        <= 1'b1;
                        done_o        <= 1'b0;
                    end
                end

                S_FREEZE: begin
                    if (retire_s) begin
                        if (core_cnt_r == last_core) begin
                            state_r     <= S_CONFIG;
                            core_cnt_r  <= '0;
                            field_cnt_r <= 3'd0;
                            cfg_core_o  <= '0;
                            cfg_addr_o  <= field_addr(3'd0);
                            cfg_data_o  <= field_data(3'd0, '0);
                        end else begin
                            core_cnt_r  <= core_next_s;
                            cfg_core_o  <= core_next_s;
                            cfg_addr_o  <= freeze_addr;
                            cfg_data_o  <= data_one;
                        end
                    end
                end

                S_CONFIG: begin
                    if (retire_s) begin
                        if (field_cnt_r == last_field) begin
                            field_cnt_r <= 3'd0;
                            if (core_cnt_r == last_core) begin
                                state_r    <= S_UNFREEZE;
                                core_cnt_r <= '0;
                                cfg_core_o <= '0;
                                cfg_addr_o <= freeze_addr;
                                cfg_data_o <= data_zero;
                            end else begin
                                core_cnt_r <= core_next_s;
                                cfg_core_o <= core_next_s;
                                cfg_addr_o <= field_addr(3'd0);
                                cfg_data_o <= field_data(3'd0, core_next_s);
                            end
                        end else begin
                            field_cnt_r <= field_next_s;
                            cfg_addr_o  <= field_addr(field_next_s);
                            cfg_data_o  <= field_data(field_next_s, core_cnt_r);
                        end
                    end
                end

                S_UNFREEZE: begin
                    if (retire_s) begin
                        if (core_cnt_r == last_core) begin
                            state_r    <= S_DONE;
                            core_cnt_r <= '0;
                            cfg_v_o    <= 1'b0;
                            cfg_core_o <= '0;
                            cfg_addr_o <= '0;
                            cfg_data_o <= '0;
                            busy_o     <= 1'b0;
                            done_o     <= 1'b1;
                        end else begin
                            core_cnt_r <= core_next_s;
                            cfg_core_o <= core_next_s;
                            cfg_addr_o <= freeze_addr;
                            cfg_data_o <= data_zero;
                        end
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to a quiet IDLE.
                    state_r     <= S_IDLE;
                    core_cnt_r  <= '0;
                    field_cnt_r <= 3'd0;
                    cfg_v_o     <= 1'b0;
                    cfg_core_o  <= '0;
                    cfg_addr_o  <= '0;
                    cfg_data_o  <= '0;
                    busy_o      <= 1'b0;
                    done_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bp_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_bp_cfg_loader
//
// Self-checking bench for bp_cfg_loader. Four instances (N = 1, 2, 4, 16)
// share the clock and the did/mode inputs; each has its own reset, start and
// ready. The expected write list of a run is built from the sequence rules
// (freeze all, five fields per core, unfreeze all) and compared in order
// against every retired write.
// -----------------------------------------------------------------------------
module tb_bp_cfg_loader;

    localparam int NINST = 4;

    function automatic int nc_of(input int g);
        case (g)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 16;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NINST-1:0]       reset;
    logic [NINST-1:0]       start;
    logic [NINST-1:0]       ready;
    logic [2:0]             did;
    logic [1:0]             icm;
    logic [1:0]             dcm;
    logic                   cce;

    logic [NINST-1:0]       v_b;
    logic [NINST-1:0]       busy_b;
    logic [NINST-1:0]       done_b;
    logic [NINST-1:0][3:0]  core_b;
    logic [NINST-1:0][15:0] addr_b;
    logic [NINST-1:0][31:0] data_b;

    for (genvar g = 0; g < NINST; g++) begin : g_dut
        localparam int NCG = nc_of(g);
        localparam int LG  = (NCG > 1) ? $clog2(NCG) : 1;
        logic          v_w, busy_w, done_w;
        logic [LG-1:0] core_w;
        logic [15:0]   addr_w;
        logic [31:0]   data_w;

        bp_cfg_loader #(
            .num_core_p        (NCG),
            .cfg_addr_width_p  (16),
            .cfg_data_width_p  (32),
            .io_noc_did_width_p(3)
        ) u_dut (
            .clk_i        (clk),
            .reset_i      (reset[g]),
            .start_i      (start[g]),
            .did_i        (did),
            .icache_mode_i(icm),
            .dcache_mode_i(dcm),
            .cce_mode_i   (cce),
            .cfg_v_o      (v_w),
            .cfg_core_o   (core_w),
            .cfg_addr_o   (addr_w),
            .cfg_data_o   (data_w),
            .cfg_ready_i  (ready[g]),
            .busy_o       (busy_w),
            .done_o       (done_w)
        );

        assign v_b[g]    = v_w;
        assign busy_b[g] = busy_w;
        assign done_b[g] = done_w;
        assign core_b[g] = 4'(core_w);
        assign addr_b[g] = addr_w;
        assign data_b[g] = data_w;
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [51:0] cur_write(input int s);
        return {core_b[s], addr_b[s], data_b[s]};
    endfunction

    function automatic logic [2:0] ctl(input int s);
        return {v_b[s], busy_b[s], done_b[s]};
    endfunction

    logic [51:0] expq[$];

    // Reference write list of one run, straight from the sequencing rules.
    task automatic build_expected(input int n, input logic [2:0] d, input logic [1:0] im,
                                  input logic [1:0] dm, input logic cm);
        int vals[5];
        expq.delete();
        vals[1] = int'(d);
        vals[2] = int'(im);
        vals[3] = int'(dm);
        vals[4] = int'(cm);
        for (int c = 0; c < n; c++) expq.push_back({4'(c), 16'h0000, 32'd1});
        for (int c = 0; c < n; c++) begin
            vals[0] = c;
            for (int f = 0; f < 5; f++) expq.push_back({4'(c), 16'(4 + 4 * f), 32'(vals[f])});
        end
        for (int c = 0; c < n; c++) expq.push_back({4'(c), 16'h0000, 32'd0});
    endtask

    // One run on instance s. rand_ready adds random back-pressure with
    // 5-cycle stalls; restart_at pulses start again on that cycle; change_in
    // scrambles did/modes every cycle; hold_start keeps start high; abort_at
    // asserts reset once that many writes have retired.
    task automatic run_seq(input int s, input logic [2:0] d, input logic [1:0] im,
                           input logic [1:0] dm, input logic cm, input bit rand_ready,
                           input int restart_at, input bit change_in, input bit hold_start,
                           input int abort_at);
        int          n;
        int          retired;
        int          cyc;
        int          stall_left;
        bit          rdy;
        bit          prev_stall;
        logic [51:0] cur;
        logic [51:0] prev;
        n   = nc_of(s);
        did = d;
        icm = im;
        dcm = dm;
        cce = cm;
        build_expected(n, d, im, dm, cm);
        start[s] = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start[s] = 1'b0;
        check_val("start_ctl", ctl(s), 3'b110);
        retired    = 0;
        cyc        = 1;
        stall_left = 0;
        prev_stall = 1'b0;
        prev       = '0;
        while (retired < 7 * n && cyc < 3000) begin
            cur = cur_write(s);
            if (prev_stall) check_val("stall_hold", cur, prev);
            check_val("run_ctl", ctl(s), 3'b110);
            if (abort_at == retired) begin
                check_val("abort_point", cur, expq[0]);
                reset[s] = 1'b1;
                ready[s] = 1'b0;
                start[s] = 1'b0;
                @(posedge clk); #1;
                reset[s] = 1'b0;
                check_val("abort_ctl", ctl(s), 3'b000);
                check_val("abort_bus", cur_write(s), 52'h0);
                return;
            end
            if (change_in) begin
                did = 3'($urandom);
                icm = 2'($urandom);
                dcm = 2'($urandom);
                cce = 1'($urandom);
            end
            if (!hold_start) start[s] = (cyc == restart_at);
            if (!rand_ready) begin
                rdy = 1'b1;
            end else if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 9) == 0) begin
                rdy = 1'b0;
                stall_left = 4;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            ready[s] = rdy;
            if (rdy) begin
                check_val("write", cur, expq.pop_front());
                retired++;
            end
            prev       = cur;
            prev_stall = !rdy;
            @(posedge clk); #1;
            cyc++;
        end
        ready[s] = 1'b0;
        check_val("retire_count", 64'(retired), 64'(7 * n));
        if (!rand_ready) check_val("done_cycle", 64'(cyc), 64'(7 * n + 1));
        check_val("done_ctl", ctl(s), 3'b001);
    endtask

    initial begin
        reset = '1;
        start = '0;
        ready = '0;
        did   = 3'd0;
        icm   = 2'd0;
        dcm   = 2'd0;
        cce   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NINST; g++) begin
            check_val("reset_ctl", ctl(g), 3'b000);
            check_val("reset_bus", cur_write(g), 52'h0);
        end
        reset = '0;
        @(posedge clk); #1;

        // N=2 directed run: did=5, modes 1/2/1, ready tied high.
        run_seq(1, 3'd5, 2'd1, 2'd2, 1'b1, 1'b0, -1, 1'b0, 1'b0, -1);

        // N=4 under random back-pressure.
        for (int r = 0; r < 3; r++)
            run_seq(2, 3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                    1'b1, -1, 1'b0, 1'b0, -1);

        // N=4: second start at the 3rd write plus inputs changing mid-run.
        run_seq(2, 3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                1'b0, 3, 1'b1, 1'b0, -1);

        // N=4: reset at CONFIG core 1 field 2, then a clean full run.
        run_seq(2, 3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                1'b1, -1, 1'b0, 1'b0, 4 + 5 + 2);
        @(posedge clk); #1;
        check_val("post_abort_idle", ctl(2), 3'b000);
        run_seq(2, 3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                1'b1, -1, 1'b0, 1'b0, -1);

        // N=1 back-to-back with start held: done lasts exactly one cycle.
        run_seq(0, 3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                1'b0, -1, 1'b0, 1'b1, -1);
        run_seq(0, 3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                1'b0, -1, 1'b0, 1'b1, -1);
        start[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("done_hold", ctl(0), 3'b001);

        // N=16, ready high then random.
        run_seq(3, 3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                1'b0, -1, 1'b0, 1'b0, -1);
        run_seq(3, 3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                1'b1, -1, 1'b1, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bp_cfg_loader.md
# bp_cfg_loader

Boot-time configuration sequencer generalised over core count and configuration fields. After a start pulse it writes freeze, core id, domain id and cache/CCE modes to every core's config space over a valid/ready config bus, then releases freeze on every core. It sits between the host/IO complex and the per-tile config bus of a multicore build. Field values are captured at start, so a run sees one consistent set.

## Interface
- num_core_p, 1: number of cores configured (1..16).
- cfg_addr_width_p, 16: config bus address width.
- cfg_data_width_p, 32: config bus data width (≥ 8).
- io_noc_did_width_p, 3: domain id width.
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  begin a run; honoured only in IDLE or DONE.
- did_i  in  io_noc_did_width_p  domain id, captured at start.
- icache_mode_i  in  2  I$ mode, captured at start.
- dcache_mode_i  in  2  D$ mode, captured at start.
- cce_mode_i  in  1  CCE mode, captured at start.
- cfg_v_o  out  1  config write valid.
- cfg_core_o  out  lg_num_core (BSG_SAFE_CLOG2(num_core_p))  target core.
- cfg_addr_o  out  cfg_addr_width_p  register address.
- cfg_data_o  out  cfg_data_width_p  write data, zero-extended.
- cfg_ready_i  in  1  bus accepts the write this cycle.
- busy_o  out  1  run in progress.
- done_o  out  1  last run completed.

## Operation
- States: IDLE, FREEZE, CONFIG, UNFREEZE, DONE. Counters: core_cnt (0..num_core_p-1), field_cnt (0..4).
- Handshake: a write retires on a cycle with cfg_v_o & cfg_ready_i. While cfg_v_o=1 and cfg_ready_i=0, all cfg_* outputs hold stable. Only a retiring write advances the counters.
- IDLE/DONE + start_i: capture did/mode inputs, clear counters, go to FREEZE. A start_i in any other state is ignored.
- FREEZE: write addr 0x0000, data 1, to cores 0..N-1 in order. The last retire goes to CONFIG.
- CONFIG: for each core 0..N-1, write fields in this order:
  - 0x0004: core id (core_cnt)
  - 0x0008: did
  - 0x000C: icache_mode
  - 0x0010: dcache_mode
  - 0x0014: cce_mode
  field_cnt wraps 4→0 and core_cnt increments. The retire of core N-1 field 4 goes to UNFREEZE.
- UNFREEZE: write addr 0x0000, data 0, to cores 0..N-1. The last retire goes to DONE.
- DONE: done_o=1 until a start_i is accepted.
- Total per run: exactly 7·N writes.
- Counter wrap: core_cnt returns to 0 at each phase change. num_core_p=1 is legal; core_cnt stays 0.
- Captured values are immune to input changes mid-run.

## Timing
- Reset values: state IDLE; cfg_v_o=0, cfg_core_o=0, cfg_addr_o=0, cfg_data_o=0, busy_o=0, done_o=0; counters 0; captured fields 0.
- reset_i mid-run aborts the sequence the next cycle. No partial write is held, and no unfreeze is issued.
- All outputs are registered.
- Start latency: start_i sampled at edge k gives cfg_v_o=1 and busy_o=1 from cycle k+1.
- With cfg_ready_i tied high, one write retires per cycle. A run therefore takes 7·N cycles of cfg_v_o, and done_o rises on the cycle after the final retire.
- busy_o = (state ∈ {FREEZE, CONFIG, UNFREEZE}). done_o and busy_o are never both 1.
- start_i in DONE clears done_o on the same edge that busy_o rises.

## Test plan
- N=2, ready=1, did=5, modes 1/2/1: 14 consecutive writes in this order:
  - (c0,0x0,1), (c1,0x0,1)
  - c0: 0x4=0, 0x8=5, 0xC=1, 0x10=2, 0x14=1
  - c1: 0x4=1, 0x8=5, 0xC=1, 0x10=2, 0x14=1
  - (c0,0x0,0), (c1,0x0,0)
  done_o rises at cycle 15 after start.
- N=4, ready toggled randomly including 5-cycle stalls: outputs stable during every stall; 28 retires in the same order; no dropped or duplicated write.
- Start pulsed again at the 3rd write, and did_i changed mid-run: no restart, and all did writes carry the captured value.
- reset_i asserted during CONFIG (core 1, field 2): next cycle cfg_v_o=0, busy_o=0, done_o=0. A new start then produces the full 7·N sequence from the beginning.
- N=1 back-to-back runs, start held high through DONE: 7 writes, done_o pulses for one cycle, then a second 7-write run begins.
- N=16: core_cnt reaches 15 and cfg_core_o is 4 bits wide; 112 writes total; core id data values 0..15.
